// File: rtl/ram_pkg.sv
// Shared constants for the simple dual-port RAM: init FSM encoding and read-during-write modes.
package ram_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT  = 1'b0;
    localparam state_t ST_READY = 1'b1;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_sdp_param_if.sv
// Access bundle for ram_sdp_param: write port, read port, clear request and status.
interface ram_sdp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic                  clr;
    logic                  we;
    logic [ADDR_W-1:0]     write_addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   be;
    logic                  re;
    logic [ADDR_W-1:0]     read_addr;
    logic [DATA_W-1:0]     q;
    logic                  q_valid;
    logic                  init_busy;

    modport master (
        output clr, we, write_addr, data, be, re, read_addr,
        input  q, q_valid, init_busy
    );

    modport slave (
        input  clr, we, write_addr, data, be, re, read_addr,
        output q, q_valid, init_busy
    );
endinterface

// File: rtl/ram_init_ctrl.sv
// INIT/READY controller: sweeps zeros over every address (DEPTH cycles) after reset or clr.
// No backpressure; clr is only honoured in READY.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              init_busy,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == LAST) begin
                        state <= ST_READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign init_busy  = (state == ST_INIT);
    assign sweep_we   = (state == ST_INIT);
    assign sweep_addr = cnt;

endmodule

// File: rtl/ram_sdp_param.sv
// Simple dual-port RAM with byte enables, self-clearing sweep and selectable read-during-write.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, accesses dropped while init_busy.
module ram_sdp_param
    import ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_sdp_param_if.slave     bus
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_busy;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;

    ram_init_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_init_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.clr),
        .init_busy  (init_busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    logic wr_in_range, rd_in_range, wr_ok, rd_ok, rdw_hit;
    logic [DATA_W-1:0] wr_word, rd_word;

    assign wr_in_range = ({1'b0, bus.write_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, bus.read_addr} < DEPTH_L);
    assign wr_ok       = !init_busy && bus.we && wr_in_range;
    assign rd_ok       = !init_busy && bus.re;
    assign rdw_hit     = wr_ok && (bus.write_addr == bus.read_addr);

    // Post-write view of the written word, only needed for new-data read-during-write.
    always_comb begin
        wr_word = wr_in_range ? mem[bus.write_addr] : '0;
        for (int b = 0; b < NB; b++) begin
            if (bus.be[b]) wr_word[8*b +: 8] = bus.data[8*b +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = (RDW_MODE == RDW_NEW && rdw_hit) ? wr_word : mem[bus.read_addr];
        end
    end

    // Storage has no reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be[b]) mem[bus.write_addr][8*b +: 8] <= bus.data[8*b +: 8];
            end
        end
    end

    logic              rd_vld;
    logic [DATA_W-1:0] rd_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            rd_vld <= rd_ok;
            if (rd_ok) rd_dat <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              q_vld_r;
            logic [DATA_W-1:0] q_dat_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_vld_r <= 1'b0;
                    q_dat_r <= '0;
                end else begin
                    q_vld_r <= rd_vld;
                    if (rd_vld) q_dat_r <= rd_dat;
                end
            end

            assign bus.q       = q_dat_r;
            assign bus.q_valid = q_vld_r;
        end else begin : g_no_out_reg
            assign bus.q       = rd_dat;
            assign bus.q_valid = rd_vld;
        end
    endgenerate

    assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param: five parameter variants share one clock and reset.
module tb_ram_sdp_param;

    logic clk;
    logic rst_n;

    logic       clr, we, re;
    logic [5:0] write_addr, read_addr;
    logic [7:0] data;
    logic [0:0] be;

    logic        we16, re16;
    logic [5:0]  wa16, ra16;
    logic [15:0] d16;
    logic [1:0]  be16;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_cnt;

    ram_sdp_param_if #(.DATA_W(8),  .ADDR_W(6)) i0 (), i1 (), i3 (), i4 ();
    ram_sdp_param_if #(.DATA_W(16), .ADDR_W(6)) i2 ();

    assign i0.clr = clr; assign i0.we = we; assign i0.write_addr = write_addr; assign i0.data = data;
    assign i0.be = be;   assign i0.re = re; assign i0.read_addr = read_addr;
    assign i1.clr = clr; assign i1.we = we; assign i1.write_addr = write_addr; assign i1.data = data;
    assign i1.be = be;   assign i1.re = re; assign i1.read_addr = read_addr;
    assign i3.clr = clr; assign i3.we = we; assign i3.write_addr = write_addr; assign i3.data = data;
    assign i3.be = be;   assign i3.re = re; assign i3.read_addr = read_addr;
    assign i4.clr = clr; assign i4.we = we; assign i4.write_addr = write_addr; assign i4.data = data;
    assign i4.be = be;   assign i4.re = re; assign i4.read_addr = read_addr;
    assign i2.clr = clr; assign i2.we = we16; assign i2.write_addr = wa16; assign i2.data = d16;
    assign i2.be = be16; assign i2.re = re16; assign i2.read_addr = ra16;

    ram_sdp_param #(.DATA_W(8))               u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    ram_sdp_param #(.DATA_W(8), .OUT_REG(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    ram_sdp_param #(.DATA_W(16))              u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
    ram_sdp_param #(.DATA_W(8), .RDW_MODE(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));
    ram_sdp_param #(.DATA_W(8), .DEPTH(48))   u4 (.clk(clk), .rst_n(rst_n), .bus(i4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr8(input logic [5:0] a, input logic [7:0] d);
        we = 1'b1; write_addr = a; data = d; be = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd8(input logic [5:0] a, input logic [7:0] exp, input string tag);
        re = 1'b1; read_addr = a;
        @(negedge clk);
        re = 1'b0;
        chk({tag, "_v"}, 32'(i0.q_valid), 1);
        chk(tag, 32'(i0.q), 32'(exp));
    endtask

    // Counts negedges with init_busy high, starting at the current negedge.
    task automatic wait_init(input string tag);
        busy_cnt = 0;
        while (i0.init_busy && busy_cnt < 200) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk(tag, 32'(busy_cnt), 64);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 64; i++) begin
            re = 1'b1; read_addr = 6'(i);
            @(negedge clk);
            chk({tag, "_v"}, 32'(i0.q_valid), 1);
            chk(tag, 32'(i0.q), 0);
        end
        re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        clr = 1'b0; we = 1'b0; re = 1'b0; write_addr = '0; read_addr = '0; data = '0; be = '0;
        we16 = 1'b0; re16 = 1'b0; wa16 = '0; ra16 = '0; d16 = '0; be16 = '0;

        // Reset state, applied asynchronously before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_q", 32'(i0.q), 0);
        chk("rst_qv", 32'(i0.q_valid), 0);
        chk("rst_busy", 32'(i0.init_busy), 1);
        chk("rst_qv_oreg", 32'(i1.q_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_len");
        read_all_zero("init_rd");

        // Single write then read, both latencies; q holds afterwards.
        wr8(6'd5, 8'hA5);
        re = 1'b1; read_addr = 6'd5;
        @(negedge clk);
        re = 1'b0;
        chk("lat1_v", 32'(i0.q_valid), 1);
        chk("lat1_q", 32'(i0.q), 'hA5);
        chk("lat2_early_v", 32'(i1.q_valid), 0);
        @(negedge clk);
        chk("lat2_v", 32'(i1.q_valid), 1);
        chk("lat2_q", 32'(i1.q), 'hA5);
        chk("hold_v", 32'(i0.q_valid), 0);
        chk("hold_q", 32'(i0.q), 'hA5);
        @(negedge clk);
        chk("hold2_v", 32'(i1.q_valid), 0);
        chk("hold2_q", 32'(i1.q), 'hA5);

        // 16-bit byte-enable merge, including a be=0 write that must change nothing.
        we16 = 1'b1; wa16 = 6'd3; d16 = 16'h1234; be16 = 2'b11;
        @(negedge clk);
        d16 = 16'hABCD; be16 = 2'b10;
        @(negedge clk);
        d16 = 16'hFFFF; be16 = 2'b00;
        @(negedge clk);
        we16 = 1'b0; re16 = 1'b1; ra16 = 6'd3;
        @(negedge clk);
        re16 = 1'b0;
        chk("be16_v", 32'(i2.q_valid), 1);
        chk("be16_q", 32'(i2.q), 'hAB34);

        // Same-address read during write: old data vs new data.
        wr8(6'd7, 8'h11);
        we = 1'b1; write_addr = 6'd7; data = 8'h22; be = 1'b1;
        re = 1'b1; read_addr = 6'd7;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("rdw_old", 32'(i0.q), 'h11);
        chk("rdw_new", 32'(i3.q), 'h22);
        @(negedge clk);
        chk("rdw_old_oreg", 32'(i1.q), 'h11);
        we = 1'b1; write_addr = 6'd7; data = 8'hFF; be = 1'b0;
        @(negedge clk);
        we = 1'b0;
        rd8(6'd7, 8'h22, "be0_keep");

        // Shallow variant: out-of-range write dropped, read returns zero with valid.
        wr8(6'd50, 8'h77);
        re = 1'b1; read_addr = 6'd50;
        @(negedge clk);
        re = 1'b0;
        chk("oor_v", 32'(i4.q_valid), 1);
        chk("oor_q", 32'(i4.q), 0);
        chk("full_depth_q", 32'(i0.q), 'h77);

        // Fill memory, then clear with a read issued in the clr cycle.
        for (int i = 0; i < 64; i++) wr8(6'(i), 8'(i + 128));
        clr = 1'b1; re = 1'b1; read_addr = 6'd10;
        @(negedge clk);
        clr = 1'b0; re = 1'b0;
        chk("clr_inflight_v", 32'(i0.q_valid), 1);
        chk("clr_inflight_q", 32'(i0.q), 'h8A);
        busy_cnt = 0;
        while (i0.init_busy && busy_cnt < 200) begin
            busy_cnt++;
            we = (busy_cnt == 40); write_addr = 6'd0; data = 8'h55; be = 1'b1;
            re = (busy_cnt == 40); read_addr = 6'd3;
            clr = (busy_cnt == 50);
            @(negedge clk);
            if (busy_cnt == 1) begin
                chk("clr_inflight_oreg_v", 32'(i1.q_valid), 1);
                chk("clr_inflight_oreg_q", 32'(i1.q), 'h8A);
            end
            if (busy_cnt == 40) chk("init_rd_ignored", 32'(i0.q_valid), 0);
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;
        chk("clr_len", 32'(busy_cnt), 64);
        read_all_zero("clr_rd");

        // Async reset while q_valid is high.
        wr8(6'd9, 8'h3C);
        re = 1'b1; read_addr = 6'd9;
        @(negedge clk);
        re = 1'b0;
        chk("pre_rst_v", 32'(i0.q_valid), 1);
        chk("pre_rst_q", 32'(i0.q), 'h3C);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_v", 32'(i0.q_valid), 0);
        chk("arst_q", 32'(i0.q), 0);
        chk("arst_busy", 32'(i0.init_busy), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("rst_len");

        // Reset at sweep count 30 restarts a full-length sweep.
        wr8(6'd9, 8'h3C);
        rd8(6'd9, 8'h3C, "pre_mid_rd");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (29) @(negedge clk);
        chk("mid_busy", 32'(i0.init_busy), 1);
        chk("mid_hold_q", 32'(i0.q), 'h3C);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_q", 32'(i0.q), 0);
        chk("mid_rst_v", 32'(i0.q_valid), 0);
        chk("mid_rst_busy", 32'(i0.init_busy), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("mid_rst_len");
        rd8(6'd9, 8'h00, "post_mid_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sdp_param.md
RAM_SDP_PARAM -- requirements
Module: ram_sdp_param

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DATA_W, 8, word width, multiple of 8
- ADDR_W, 6, address width
- DEPTH, 2**ADDR_W, number of words
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data
- OUT_REG, 0, 1 adds an output register stage
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- clr, in, 1, pulse in READY starts a full memory clear
- we, in, 1, write enable
- write_addr, in, ADDR_W, write address
- data, in, DATA_W, write data
- be, in, DATA_W/8, byte enables, bit i covers data[8i+7:8i]
- re, in, 1, read enable
- read_addr, in, ADDR_W, read address
- q, out, DATA_W, read data
- q_valid, out, 1, q carries data for an accepted read this cycle
- init_busy, out, 1, clear sweep in progress; accesses ignored

Function
REQ-003 The FSM SHALL have two states, INIT and READY; reset enters INIT with sweep counter 0.
REQ-004 In INIT, the block SHALL write all-zero to address = counter each cycle, increment counter, and enter READY after address DEPTH-1, so the sweep takes exactly DEPTH cycles.
REQ-005 init_busy SHALL be 1 exactly while in INIT; we, re and clr SHALL be ignored in INIT.
REQ-006 In READY, clr=1 SHALL enter INIT with counter 0 on the next edge; a we/re in the same cycle SHALL still be performed.
REQ-007 A write in READY SHALL update only the bytes with be[i]=1 at write_addr on the clock edge; be=0 with we=1 SHALL leave memory unchanged.
REQ-008 A read accepted (re=1, READY) at edge N SHALL drive q and q_valid=1 after edge N+1 when OUT_REG=0, and after edge N+2 when OUT_REG=1, for one cycle per read.
REQ-009 Back-to-back reads SHALL be accepted every cycle with full throughput.
REQ-010 q SHALL hold its last value when q_valid=0.
REQ-011 Same-address read and write in one cycle: RDW_MODE=0 SHALL return the pre-write word; RDW_MODE=1 SHALL return the post-write word (byte-merged per be).
REQ-012 Addresses are unsigned ADDR_W bits; when DEPTH < 2**ADDR_W, writes to address >= DEPTH SHALL be dropped and reads SHALL return zero with q_valid=1.
REQ-013 Reads in flight when clr is accepted SHALL complete with their pre-clear data.

Reset
REQ-014 Asserting rst_n=0 SHALL immediately set q=0, q_valid=0, pipeline valids=0, state=INIT, counter=0 and init_busy=1, independent of clk.
REQ-015 Reset mid-sweep SHALL restart the sweep at address 0; memory array contents SHALL NOT be reset directly, only by the sweep.
REQ-016 The first sweep write SHALL occur on the first rising clk edge after rst_n deasserts.

Structure
REQ-017 Package ram_pkg SHALL hold the FSM state encoding (INIT, READY) and the RDW_OLD=0 and RDW_NEW=1 constants.
REQ-018 The INIT/READY FSM and sweep counter SHALL live in one sub-module, ram_init_ctrl, which outputs init_busy, sweep address and sweep write enable; the storage array and read path stay in ram_sdp_param.

Verification
REQ-019 The bench SHALL cover these directed scenarios with default parameters unless stated:
- Reset, then idle for 64 cycles: init_busy=1 for exactly 64 cycles. A read of each address 0..63 returns 0x00 with q_valid one cycle after re.
- Write 0xA5 to address 5, then read address 5 with OUT_REG=0 and then OUT_REG=1: q=0xA5, with latency 1 and 2 respectively.
- DATA_W=16: write 0x1234 (be=11) then 0xABCD (be=10) to address 3: a read returns 0xAB34.
- Address 7 holds 0x11; write 0x22 and read address 7 in the same cycle: q=0x11 for RDW_MODE=0 and 0x22 for RDW_MODE=1.
- Pulse clr after filling memory: init_busy=1 for 64 cycles, then all reads return 0. A write issued during INIT is lost.
- Assert rst_n at sweep count 30: q_valid and q drop immediately, and the sweep restarts at 0, taking 64 cycles.
